// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_e  : controller state encoding (idle / run / pause)
//   ONES_MAX : last value of a ones digit before it wraps
//   TENS_MAX : last value of a tens digit before it wraps
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  localparam int unsigned ONES_MAX = 9;
  localparam int unsigned TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch chain.
//   clk, rst_n : system clock, async active-low reset
//   inc        : advance the digit by one (wraps MAX -> 0)
//   clr        : synchronous clear to 0, dominates inc
//   value      : registered digit value
//   carry      : combinational, inc & (value == MAX); feeds the next digit
module bcd_digit_counter #(
  parameter int unsigned MAX   = 9,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] value,
  output logic             carry
);

  localparam logic [Width-1:0] ValMax = Width'(MAX);

  logic [Width-1:0] value_q, value_d;
  logic             at_max;

  assign at_max = (value_q == ValMax);
  assign carry  = inc & at_max;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear MM:SS stopwatch counting rising edges of a divided tick level.
//   clk, rst_n          : system clock, async active-low reset
//   tick_in             : divided clock level (same domain, no synchronizer)
//   start_stop          : 1-cycle pulse toggling run/pause (idle -> run)
//   clear               : 1-cycle pulse returning to idle at 00:00
//   sec_ones..min_tens  : registered BCD digits
//   running             : registered, high while in run
//   rollover            : registered 1-cycle pulse on the 59:59 -> 00:00 wrap
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam int unsigned PresW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICKS_PER_SEC - 1);

  state_e           state_q;
  logic [PresW-1:0] presc_q;
  logic             tick_prev_q;
  logic             running_q;
  logic             rollover_q;

  logic tick_rise;
  logic sec_adv;
  logic so_carry, st_carry, mo_carry, mt_carry;

  assign tick_rise = tick_in & ~tick_prev_q;
  assign sec_adv   = (state_q == StRun) & tick_rise & (presc_q == PresLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      tick_prev_q <= 1'b0;
      running_q   <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      tick_prev_q <= tick_in;
      // Wrap pulse coincides with the digits first showing 00:00; clear suppresses it.
      rollover_q  <= mt_carry & ~clear;
      if (clear) begin
        state_q   <= StIdle;
        presc_q   <= '0;
        running_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_stop) begin
              state_q   <= StRun;
              presc_q   <= '0;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            // The tick is still counted on the cycle that pauses.
            if (tick_rise) begin
              presc_q <= (presc_q == PresLast) ? '0 : presc_q + PresW'(1);
            end
            if (start_stop) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end
          end
          StPause: begin
            if (start_stop) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= StIdle;
            presc_q   <= '0;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_digit_counter #(.MAX(ONES_MAX), .Width(4)) u_sec_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_adv),
    .clr   (clear),
    .value (sec_ones),
    .carry (so_carry)
  );

  bcd_digit_counter #(.MAX(TENS_MAX), .Width(3)) u_sec_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (so_carry),
    .clr   (clear),
    .value (sec_tens),
    .carry (st_carry)
  );

  bcd_digit_counter #(.MAX(ONES_MAX), .Width(4)) u_min_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (st_carry),
    .clr   (clear),
    .value (min_ones),
    .carry (mo_carry)
  );

  bcd_digit_counter #(.MAX(TENS_MAX), .Width(3)) u_min_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mo_carry),
    .clr   (clear),
    .value (min_tens),
    .carry (mt_carry)
  );

  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICKS_PER_SEC=2 and tick_in toggling every 3 clocks.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       running;
  logic       rollover;

  int checks = 0;
  int errors = 0;
  int roll_cnt = 0;

  typedef struct {
    string       tag;
    logic [13:0] digits;
    logic        run;
  } exp_t;

  exp_t sb_q[$];

  stopwatch_ctrl #(.TICKS_PER_SEC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rollover) roll_cnt++;

  // Queue the expected MM:SS / running state for the stimulus about to be applied.
  task automatic sb_push(input string tag, input int mm, input int ss, input logic run);
    exp_t e;
    e.tag    = tag;
    e.digits = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    e.run    = run;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [13:0] obs;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries required >=1");
      return;
    end
    e   = sb_q.pop_front();
    obs = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    assert (obs === e.digits) else begin
      errors++;
      $error("FAIL %s digits: got %h required %h", e.tag, obs, e.digits);
    end
    checks++;
    assert (running === e.run) else begin
      errors++;
      $error("FAIL %s running: got %b required %b", e.tag, running, e.run);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // One full tick period: high 3 clocks, low 3 clocks.
  task automatic rise(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    sb_push("reset", 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    sb_check();
    check_bit("reset_rollover", rollover, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Reset mid-run
    pulse_ss();
    rise(14);
    sb_push("run_to_7", 0, 7, 1'b1);
    sb_check();
    #2 rst_n = 1'b0;
    sb_push("async_reset", 0, 0, 1'b0);
    #1 sb_check();
    #1 rst_n = 1'b1;
    @(negedge clk);
    pulse_ss();
    sb_push("after_reset", 0, 1, 1'b1);
    rise(2);
    sb_check();

    // 2. Basic count
    pulse_clear();
    pulse_ss();
    sb_push("basic", 0, 2, 1'b1);
    rise(4);
    sb_check();
    check_int("basic_no_rollover", roll_cnt, 0);

    // 3. Carries
    pulse_clear();
    pulse_ss();
    sb_push("to_00_59", 0, 59, 1'b1);
    rise(118);
    sb_check();
    sb_push("carry_01_00", 1, 0, 1'b1);
    rise(2);
    sb_check();
    sb_push("to_09_59", 9, 59, 1'b1);
    rise(1078);
    sb_check();
    sb_push("carry_10_00", 10, 0, 1'b1);
    rise(2);
    sb_check();

    // 4. Wrap
    sb_push("to_59_59", 59, 59, 1'b1);
    rise(5998);
    sb_check();
    check_int("no_early_rollover", roll_cnt, 0);
    rise(1);
    tick_in = 1'b1;
    sb_push("wrap", 0, 0, 1'b1);
    @(negedge clk);
    sb_check();
    check_bit("wrap_rollover_hi", rollover, 1'b1);
    @(negedge clk);
    check_bit("wrap_rollover_lo", rollover, 1'b0);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rollover_one_cycle", roll_cnt, 1);
    sb_push("after_wrap", 0, 1, 1'b1);
    rise(2);
    sb_check();

    // 5. Pause with retained prescaler, steady-high tick across resume
    pulse_clear();
    pulse_ss();
    rise(1);
    sb_push("pause", 0, 0, 1'b0);
    pulse_ss();
    sb_check();
    sb_push("paused_ticks", 0, 0, 1'b0);
    rise(10);
    sb_check();
    tick_in = 1'b1;
    @(negedge clk);
    sb_push("resume_tick_high", 0, 0, 1'b1);
    pulse_ss();
    repeat (3) @(negedge clk);
    sb_check();
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    sb_push("resume_one_rise", 0, 1, 1'b1);
    rise(1);
    sb_check();

    // 6. Priority: clear beats start_stop
    pulse_clear();
    pulse_ss();
    rise(10);
    clear = 1'b1;
    start_stop = 1'b1;
    sb_push("clear_and_ss", 0, 0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    sb_check();
    sb_push("idle_ignores", 0, 0, 1'b0);
    rise(2);
    sb_check();

    // start_stop with the second-completing rise: advance then pause
    pulse_ss();
    rise(7);
    tick_in = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    repeat (2) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    sb_push("ss_with_adv", 0, 4, 1'b0);
    sb_check();
    sb_push("stays_paused", 0, 4, 1'b0);
    rise(2);
    sb_check();

    // clear with the second-completing rise
    pulse_ss();
    rise(1);
    tick_in = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sb_push("clear_with_adv", 0, 0, 1'b0);
    sb_check();
    check_bit("clear_with_adv_rollover", rollover, 1'b0);
    repeat (2) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rollover_total", roll_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
